sha256_pad: RTL and testbench
=============================

SHA256_PAD -- requirements
Module: sha256_pad

Interface
REQ-001 Parameter: NUM_OF_WORDS, 20, message length in 32-bit words; legal range 1..4096.
REQ-002 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: start  in  1  one-cycle request to pad the message; sampled only in IDLE.
REQ-005 Port: message_addr  in  16  word address of message word 0; latched on accepted start.
REQ-006 Port: mem_clk  out  1  equals clk.
REQ-007 Port: mem_we  out  1  constant 0; the block only reads.
REQ-008 Port: mem_addr  out  16  read address, combinational: latched base + global word index g.
REQ-009 Port: mem_read_data  in  32  synchronous-RAM data, valid one cycle after the address is sampled.
REQ-010 Port: out_valid  out  1  out_data holds a valid padded word.
REQ-011 Port: out_ready  in  1  downstream compression core accepts the word.
REQ-012 Port: out_data  out  32  padded word.
REQ-013 Port: out_idx  out  4  word position within its block, equal to g[3:0].
REQ-014 Port: out_last_blk  out  1  word belongs to the final 512-bit block.
REQ-015 Port: done  out  1  one-cycle pulse after the last word is accepted.

Function
REQ-016 The block SHALL compute NB = (NUM_OF_WORDS+18)/16 (integer division) and T = 16*NB total output words.
REQ-017 Word value at g:
- g<N: mem[base+g]
- g==N: 32'h80000000
- g==T-2: 32'h00000000 (length high half)
- g==T-1: N*32
- otherwise: 0.
REQ-018 FSM states: IDLE, RD_REQ, RD_WAIT, OUT, DONE.
REQ-019 IDLE with start=1: latch message_addr, set g=0, go to RD_REQ. start=0 stays in IDLE.
REQ-020 RD_REQ: mem_addr=base+g is sampled on the edge; go to RD_WAIT.
REQ-021 RD_WAIT: register mem_read_data into out_data; go to OUT.
REQ-022 On entry to OUT without a read (g>=N), out_data SHALL be loaded with the REQ-017 pad value on the same edge.
REQ-023 In OUT, out_valid=1; out_data, out_idx and out_last_blk SHALL stay stable until out_valid && out_ready.
REQ-024 On handshake:
- g==T-1: go to DONE.
- otherwise g<=g+1; if g+1<N go to RD_REQ, else stay in OUT with the next pad word.
REQ-025 out_last_blk SHALL be 1 iff g >= T-16.
REQ-026 DONE: done=1 for exactly one cycle, then go to IDLE.
REQ-027 start asserted outside IDLE SHALL be ignored with no effect.
REQ-028 mem_addr SHALL wrap modulo 2^16.
REQ-029 g SHALL be at least 13 bits wide; length arithmetic SHALL be 32-bit.
REQ-030 Throughput: message words take 3 cycles each with out_ready=1; pad words take 1 cycle each.

Reset
REQ-031 With reset=1 at a clock edge: state=IDLE, out_valid=0, done=0, out_data=0, out_idx=0, out_last_blk=0, g=0. This applies in every state, including mid-block.
REQ-032 After reset is released, no output SHALL appear until a new start.

Verification
REQ-033 N=20, mem[base+i]=32'h1000+i, out_ready=1 -> 32 words:
- words 0..19 = 1000..1013
- word 20 = 80000000
- words 21..30 = 0
- word 31 = 00000280
- out_last_blk from word 16; done pulses once.
REQ-034 N=13 -> single block: word 13 = 80000000, word 14 = 0, word 15 = 000001A0; out_last_blk high throughout.
REQ-035 N=14 -> two blocks: word 14 = 80000000, word 15 = 0, words 16..29 = 0, word 31 = 000001C0.
REQ-036 out_ready held low 5 cycles during word 3 -> out_data and out_idx unchanged; no word dropped or duplicated.
REQ-037 reset pulsed during word 18 of N=20 -> next cycle out_valid=0, done=0; a new start then replays from word 0 at the newly latched message_addr.
REQ-038 start pulsed mid-transfer with a different message_addr -> ignored; mem_addr sequence continues from the original base.

Source files
------------

// File: rtl/sha256_pad.sv
// SHA-256 message padder.
// Reads an NUM_OF_WORDS-word message from a synchronous RAM and streams it
// out one 32-bit word at a time with SHA-256 padding appended: a single '1'
// bit (0x80000000 word), zero fill, then the 64-bit big-endian bit length.
// The output is grouped into 512-bit blocks of 16 words.
//
// Ports:
//   clk, reset      - single clock, synchronous active-high reset
//   start           - request to pad; only honoured while idle
//   message_addr    - word address of message word 0, latched on start
//   mem_clk/mem_we  - RAM clock (equal to clk) and write enable (always 0)
//   mem_addr        - RAM read address, base + word index (wraps at 2^16)
//   mem_read_data   - RAM read data, one cycle after the address is sampled
//   out_valid/out_ready/out_data - padded word stream with handshake
//   out_idx         - word position within its 512-bit block
//   out_last_blk    - word belongs to the final block
//   done            - one-cycle pulse after the last word is accepted
module sha256_pad #(
    parameter int NUM_OF_WORDS = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] message_addr,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    input  logic [31:0] mem_read_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [3:0]  out_idx,
    output logic        out_last_blk,
    output logic        done
);

    // Room for the 0x80000000 word plus the two length words forces the +18.
    localparam int NB = (NUM_OF_WORDS + 18) / 16;
    localparam int T  = 16 * NB;

    localparam logic [12:0] N_G    = 13'(NUM_OF_WORDS);
    localparam logic [12:0] LAST_G = 13'(T - 1);
    localparam logic [12:0] LBLK_G = 13'(T - 16);
    localparam logic [31:0] LEN_BITS = 32'(NUM_OF_WORDS) * 32'd32;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] OUT     = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    logic [2:0]  state;
    logic [12:0] g;
    logic [12:0] g_nxt;
    logic [15:0] base;

    // Padding content for any index past the message body.
    function automatic logic [31:0] pad_word(input logic [12:0] idx);
        if (idx == N_G)
            return 32'h8000_0000;
        else if (idx == LAST_G)
            return LEN_BITS;
        else
            return 32'h0;
    endfunction

    assign g_nxt    = g + 13'd1;
    assign mem_clk  = clk;
    assign mem_we   = 1'b0;
    assign mem_addr = base + {3'b000, g};

    assign out_valid    = (state == OUT);
    assign done         = (state == DONE);
    assign out_idx      = g[3:0];
    assign out_last_blk = out_valid && (g >= LBLK_G);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            g        <= '0;
            base     <= '0;
            out_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base  <= message_addr;
                        g     <= '0;
                        state <= RD_REQ;
                    end
                end
                RD_REQ:  state <= RD_WAIT;
                RD_WAIT: begin
                    out_data <= mem_read_data;
                    state    <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        if (g == LAST_G) begin
                            state <= DONE;
                        end else begin
                            g <= g_nxt;
                            // Message words go back through the RAM; pad
                            // words are generated directly without a read.
                            if (g_nxt < N_G)
                                state <= RD_REQ;
                            else
                                out_data <= pad_word(g_nxt);
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_pad.sv
// Bench for sha256_pad: three instances (N=20, 13, 14) sharing one RAM model.
// Expected words are derived from the padding rules applied to the RAM array.
module tb_sha256_pad;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [2:0]  start;
    logic [15:0] msg_addr;
    logic [2:0]  mem_clk, mem_we, out_valid, out_ready, out_last_blk, done;
    logic [2:0][15:0] mem_addr;
    logic [2:0][31:0] out_data;
    logic [2:0][3:0]  out_idx;

    logic [31:0] mem [0:65535];

    int total = 0;
    int bad   = 0;

    genvar k;
    generate
        for (k = 0; k < 3; k++) begin : g_dut
            localparam int NW = (k == 0) ? 20 : (k == 1) ? 13 : 14;
            logic [31:0] rd;
            always @(posedge clk) rd <= mem[mem_addr[k]];
            sha256_pad #(.NUM_OF_WORDS(NW)) dut (
                .clk(clk), .reset(reset), .start(start[k]),
                .message_addr(msg_addr), .mem_clk(mem_clk[k]), .mem_we(mem_we[k]),
                .mem_addr(mem_addr[k]), .mem_read_data(rd),
                .out_valid(out_valid[k]), .out_ready(out_ready[k]),
                .out_data(out_data[k]), .out_idx(out_idx[k]),
                .out_last_blk(out_last_blk[k]), .done(done[k])
            );
        end
    endgenerate

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nw_of(input int i);
        return (i == 0) ? 20 : (i == 1) ? 13 : 14;
    endfunction

    // Padded message as a plain sequence: body, 0x80000000, zeros, 64-bit length.
    function automatic logic [31:0] exp_word(input logic [15:0] base, input int g, input int nw);
        int t = 16 * ((nw + 18) / 16);
        if (g < nw)      return mem[16'(int'(base) + g)];
        if (g == nw)     return 32'h8000_0000;
        if (g == t - 1)  return 32'(nw * 32);
        return 32'h0;
    endfunction

    // mode: 0 ready=1, 1 stall 5 cycles at word 3, 2 spurious start at word 5,
    //       3 reset at word 18, 4 random ready
    task automatic run_msg(input int i, input logic [15:0] base, input int mode);
        int nw = nw_of(i);
        int t  = 16 * ((nw + 18) / 16);
        int got = 0, cyc = 0, dones = 0, stall_left = 5, late_valid = 0;
        bit pend = 0, kicked = 0, r;
        logic [31:0] hd;
        logic [3:0]  hi;
        @(negedge clk);
        msg_addr     = base;
        start[i]     = 1'b1;
        out_ready[i] = 1'b1;
        while (cyc < 3000 && !(got == t && dones > 0)) begin
            @(negedge clk);
            cyc++;
            start[i] = 1'b0;
            if (done[i]) dones++;
            if (pend) begin
                chk("hold_valid", out_valid[i], 1);
                chk("hold_data", out_data[i], hd);
                chk("hold_idx", out_idx[i], hi);
                pend = 0;
            end
            if (mode == 2 && got == 5 && !kicked) begin
                start[i] = 1'b1;
                msg_addr = ~base;
                kicked   = 1;
            end
            if (mode == 3 && got == 18 && out_valid[i]) begin
                out_ready[i] = 1'b0;
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                chk("rst_valid", out_valid[i], 0);
                chk("rst_done", done[i], 0);
                chk("rst_data", out_data[i], 0);
                chk("rst_idx", out_idx[i], 0);
                chk("rst_last", out_last_blk[i], 0);
                for (int c = 0; c < 6; c++) begin
                    @(negedge clk);
                    if (out_valid[i] || done[i]) late_valid++;
                end
                chk("rst_quiet", late_valid, 0);
                out_ready[i] = 1'b1;
                return;
            end
            if (out_valid[i]) begin
                if (mode == 1 && got == 3 && stall_left > 0) begin
                    r = 0;
                    stall_left--;
                end else begin
                    r = (mode == 4) ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                out_ready[i] = r;
                if (r) begin
                    chk($sformatf("data[%0d]", got), out_data[i], exp_word(base, got, nw));
                    chk($sformatf("idx[%0d]", got), out_idx[i], 32'(got % 16));
                    chk($sformatf("last[%0d]", got), out_last_blk[i], (got >= t - 16) ? 1 : 0);
                    got++;
                end else begin
                    pend = 1;
                    hd   = out_data[i];
                    hi   = out_idx[i];
                end
            end else begin
                out_ready[i] = 1'b1;
            end
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done[i]) dones++;
            if (out_valid[i]) late_valid++;
        end
        chk("word_count", got, t);
        chk("done_pulses", dones, 1);
        chk("idle_after", late_valid, 0);
        if (mode == 1) chk("stall_cycles", stall_left, 0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = '0;
        out_ready = '1;
        msg_addr  = '0;
        for (int a = 0; a < 65536; a++) mem[a] = $urandom;
        for (int a = 0; a < 20; a++) mem[16'h0100 + a] = 32'h1000 + a;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset_valid", out_valid[i], 0);
            chk("reset_done", done[i], 0);
            chk("reset_data", out_data[i], 0);
            chk("reset_idx", out_idx[i], 0);
            chk("reset_last", out_last_blk[i], 0);
            chk("mem_we", mem_we[i], 0);
        end
        chk("mem_clk", mem_clk[0], clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_reset_quiet", {29'd0, out_valid}, 0);

        run_msg(0, 16'h0100, 0);                       // N=20 directed contents
        run_msg(1, 16'($urandom), 0);                  // N=13 single block
        run_msg(2, 16'($urandom), 0);                  // N=14 two blocks
        run_msg(0, 16'($urandom), 1);                  // backpressure on word 3
        run_msg(0, 16'($urandom), 2);                  // start ignored mid-run
        run_msg(0, 16'($urandom), 3);                  // reset during word 18
        run_msg(0, 16'($urandom), 0);                  // replay after reset
        run_msg(0, 16'hFFF5, 0);                       // address wrap
        for (int i = 0; i < 3; i++) run_msg(i, 16'($urandom), 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
